// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them in order (bit 0 first) with fixed spacing.
// All outputs registered; any hold condition (rst, ext_rst_n low, sw_rst_req) drops every output on that edge.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ext_rst_n,
  input  logic                             sw_rst_req,
  output logic [NUM_DOMAINS-1:0]           rst_n_out,
  output logic [$clog2(NUM_DOMAINS+1)-1:0] rel_cnt,
  output logic                             seq_busy,
  output logic                             seq_done
);

  localparam int CW = $clog2(NUM_DOMAINS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGE_DELAY + 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [HW-1:0]          r_hold_cnt, w_hold_nxt;
  logic [SW-1:0]          r_stage_cnt, w_stage_nxt;
  logic [CW-1:0]          r_rel_cnt, w_rel_nxt;
  logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n_nxt;
  logic                   r_done, r_busy;
  logic                   w_hold;
  logic                   w_done_nxt;

  assign w_hold = rst | ~ext_rst_n | sw_rst_req;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_stage_nxt = r_stage_cnt;
    w_rel_nxt   = r_rel_cnt;
    if (w_hold) begin
      w_state_nxt = S_HOLD;
      w_hold_nxt  = '0;
      w_stage_nxt = '0;
      w_rel_nxt   = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          // Release fires on the clean edge after HOLD_CYCLES clean edges have been counted.
          if (r_hold_cnt == HW'(HOLD_CYCLES)) begin
            w_rel_nxt   = CW'(1);
            w_hold_nxt  = '0;
            w_stage_nxt = '0;
            w_state_nxt = S_RELEASE;
          end else begin
            w_hold_nxt = r_hold_cnt + HW'(1);
          end
        end
        S_RELEASE: begin
          if (r_stage_cnt == SW'(STAGE_DELAY - 1)) begin
            w_rel_nxt   = r_rel_cnt + CW'(1);
            w_stage_nxt = '0;
            if (w_rel_nxt == CW'(NUM_DOMAINS)) begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_stage_nxt = r_stage_cnt + SW'(1);
          end
        end
        S_RUN: begin
          w_rel_nxt = CW'(NUM_DOMAINS);
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = '0;
          w_stage_nxt = '0;
          w_rel_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are a thermometer of the release count, so ordering holds by construction.
  always_comb begin
    w_rst_n_nxt = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      w_rst_n_nxt[k] = (int'(w_rel_nxt) > k);
    end
  end

  assign w_done_nxt = (w_state_nxt == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      r_stage_cnt <= '0;
      r_rel_cnt   <= '0;
      r_rst_n     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_stage_cnt <= w_stage_nxt;
      r_rel_cnt   <= w_rel_nxt;
      r_rst_n     <= w_rst_n_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= ~w_done_nxt;
    end
  end

  assign rst_n_out = r_rst_n;
  assign rel_cnt   = r_rel_cnt;
  assign seq_done  = r_done;
  assign seq_busy  = r_busy;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: default instance plus a minimal (2/1/1) instance sharing the same stimulus.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;

  logic [3:0] rst_n_out;
  logic [2:0] rel_cnt;
  logic       seq_busy, seq_done;

  logic [1:0] rst_n_out2;
  logic [1:0] rel_cnt2;
  logic       seq_busy2, seq_done2;

  int checks = 0;
  int errors = 0;
  int clean_run = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUM_DOMAINS(4), .HOLD_CYCLES(8), .STAGE_DELAY(4)) u_dut (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out), .rel_cnt(rel_cnt), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  rst_seq_ctrl #(.NUM_DOMAINS(2), .HOLD_CYCLES(1), .STAGE_DELAY(1)) u_dut2 (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .rst_n_out(rst_n_out2), .rel_cnt(rel_cnt2), .seq_busy(seq_busy2), .seq_done(seq_done2)
  );

  // Model: count consecutive clean edges; released domains follow from that count alone.
  always @(posedge clk) begin
    if (rst || !ext_rst_n || sw_rst_req) clean_run <= 0;
    else if (clean_run < 10000) clean_run <= clean_run + 1;
  end

  function automatic int exp_rel(int c, int n, int h, int s);
    int r;
    if (c <= h) return 0;
    r = 1 + (c - 1 - h) / s;
    if (r > n) r = n;
    return r;
  endfunction

  task automatic cmp(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int r1, r2;
      r1 = exp_rel(clean_run, 4, 8, 4);
      r2 = exp_rel(clean_run, 2, 1, 1);
      cmp("model_out",  int'(rst_n_out), (1 << r1) - 1);
      cmp("model_rel",  int'(rel_cnt), r1);
      cmp("model_done", int'(seq_done), int'(r1 == 4));
      cmp("model_busy", int'(seq_busy), int'(r1 != 4));
      cmp("model2_out", int'(rst_n_out2), (1 << r2) - 1);
      cmp("model2_rel", int'(rel_cnt2), r2);
      cmp("model2_done", int'(seq_done2), int'(r2 == 2));
      for (int k = 1; k < 4; k++) begin
        if (rst_n_out[k]) cmp("thermo", int'(rst_n_out[k-1]), 1);
      end
      if (rst_n_out2[1]) cmp("thermo2", int'(rst_n_out2[0]), 1);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(string name, int out_exp, int rel_exp, int done_exp);
    cmp({name, "_out"},  int'(rst_n_out), out_exp);
    cmp({name, "_rel"},  int'(rel_cnt), rel_exp);
    cmp({name, "_done"}, int'(seq_done), done_exp);
    cmp({name, "_busy"}, int'(seq_busy), 1 - done_exp);
  endtask

  initial begin
    // Power-up
    tick(1);
    chk_en = 1'b1;
    lit("reset", 0, 0, 0);
    tick(2);
    rst = 1'b0;
    tick(1);                       // T0
    cmp("sw2_t0", int'(rst_n_out2), 0);
    tick(1);                       // T0+1
    cmp("sw2_t1", int'(rst_n_out2), 1);
    tick(1);                       // T0+2
    cmp("sw2_t2", int'(rst_n_out2), 3);
    cmp("sw2_done", int'(seq_done2), 1);
    tick(5);                       // T0+7
    lit("pu_t7", 4'b0000, 0, 0);
    tick(1);
    lit("pu_t8", 4'b0001, 1, 0);
    tick(4);
    lit("pu_t12", 4'b0011, 2, 0);
    tick(4);
    lit("pu_t16", 4'b0111, 3, 0);
    tick(3);
    lit("pu_t19", 4'b0111, 3, 0);
    tick(1);
    lit("pu_t20", 4'b1111, 4, 1);

    // Software reset pulse in RUN
    tick(3);
    sw_rst_req = 1'b1;
    tick(1);                       // edge E
    sw_rst_req = 1'b0;
    lit("sw_e", 0, 0, 0);
    tick(8);
    lit("sw_e8", 0, 0, 0);
    tick(1);
    lit("sw_e9", 4'b0001, 1, 0);
    tick(12);
    lit("sw_e21", 4'b1111, 4, 1);

    // Software reset mid-RELEASE at T0+14
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(14);                      // T0+13
    lit("mid_t13", 4'b0011, 2, 0);
    sw_rst_req = 1'b1;
    tick(1);                       // T0+14
    sw_rst_req = 1'b0;
    lit("mid_t14", 0, 0, 0);
    tick(8);                       // T0'+7
    lit("mid_t7p", 0, 0, 0);
    tick(1);
    lit("mid_t8p", 4'b0001, 1, 0);
    tick(12);
    lit("mid_run", 4'b1111, 4, 1);

    // ext_rst_n low for 5 cycles in RUN
    ext_rst_n = 1'b0;
    tick(1);
    lit("ext_1", 0, 0, 0);
    tick(4);
    lit("ext_5", 0, 0, 0);
    ext_rst_n = 1'b1;
    tick(8);                       // T0+7
    lit("ext_t7", 0, 0, 0);
    tick(1);
    lit("ext_t8", 4'b0001, 1, 0);
    tick(12);
    lit("ext_run", 4'b1111, 4, 1);

    // Back-to-back sw pulses, then rst together with sw mid-HOLD
    sw_rst_req = 1'b1;
    tick(3);
    sw_rst_req = 1'b0;
    lit("b2b", 0, 0, 0);
    tick(4);
    rst = 1'b1;
    sw_rst_req = 1'b1;
    tick(1);
    rst = 1'b0;
    sw_rst_req = 1'b0;
    lit("rst_sw", 0, 0, 0);
    tick(8);
    lit("rst_t7", 0, 0, 0);
    tick(1);
    lit("rst_t8", 4'b0001, 1, 0);
    tick(12);
    lit("rst_run", 4'b1111, 4, 1);
    tick(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
